// File: rtl/serial_pkg.sv
// ============================================================================
// serial_pkg: shared state encoding and helpers for the serial packet framer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  // A single-entry buffer still needs a one-bit address.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_buffer.sv
// ============================================================================
// pkt_buffer: DEPTH x 8 register file, synchronous write, combinational read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pkt_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (int'(rd_addr_i) < DEPTH) ? mem_q[rd_addr_i] : 8'h00;

endmodule

`default_nettype wire

// File: rtl/serial_packet_ctrl.sv
// ============================================================================
// serial_packet_ctrl: sync hunt, length/XOR-checked framing, valid/ready drain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_packet_ctrl
  import serial_pkg::*;
#(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic [7:0] pkt_data,
  output logic       pkt_last,
  output logic [7:0] pkt_len,
  output logic       busy,
  output logic       err_length,
  output logic       err_checksum,
  output logic       err_timeout,
  output logic       err_overflow
);

  localparam int PTR_W  = ptr_width(MAX_LEN);
  localparam int IDLE_W = $clog2(TIMEOUT);
  // Firing one count early means the abort lands after TIMEOUT-1 silent cycles.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 2);
  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]        state_q,   state_d;
  logic [7:0]        len_q,     len_d;
  logic [7:0]        chk_q,     chk_d;
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [IDLE_W-1:0] idle_q,    idle_d;
  logic              err_len_q, err_len_d;
  logic              err_chk_q, err_chk_d;
  logic              err_tmo_q, err_tmo_d;
  logic              err_ovf_q, err_ovf_d;

  logic       w_buf_we;
  logic [7:0] w_buf_rdata;
  logic [7:0] w_len_m1;
  logic       w_wr_at_last;
  logic       w_rd_at_last;
  logic       w_timed;
  logic       w_draining;

  assign w_len_m1     = len_q - 8'd1;
  assign w_wr_at_last = (8'(wr_ptr_q) == w_len_m1);
  assign w_rd_at_last = (8'(rd_ptr_q) == w_len_m1);
  assign w_timed      = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) ||
                        (state_q == ST_CHECK);
  assign w_draining   = (state_q == ST_DRAIN);

  pkt_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (PTR_W)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (w_buf_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (byte_in),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (w_buf_rdata)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    chk_d     = chk_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    idle_d    = idle_q;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovf_d = 1'b0;
    w_buf_we  = 1'b0;

    // A byte on the would-be timeout cycle takes priority over the abort.
    if (w_timed) begin
      if (byte_valid) begin
        idle_d = '0;
      end else if (idle_q == IDLE_LAST) begin
        idle_d    = '0;
        err_tmo_d = 1'b1;
        state_d   = ST_HUNT;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end

    case (state_q)
      ST_HUNT: begin
        if (byte_valid && (byte_in == SYNC_BYTE)) begin
          state_d = ST_LEN;
          idle_d  = '0;
        end
      end
      ST_LEN: begin
        if (byte_valid) begin
          if ((byte_in != 8'd0) && (byte_in <= MAX_LEN_B)) begin
            len_d    = byte_in;
            chk_d    = byte_in;
            wr_ptr_d = '0;
            state_d  = ST_PAYLOAD;
          end else begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_valid) begin
          w_buf_we = 1'b1;
          chk_d    = chk_q ^ byte_in;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (w_wr_at_last) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (byte_valid) begin
          if (byte_in == chk_q) begin
            rd_ptr_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end
      end
      ST_DRAIN: begin
        err_ovf_d = byte_valid;
        if (pkt_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (w_rd_at_last) begin
            state_d = ST_HUNT;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      len_q     <= '0;
      chk_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      idle_q    <= '0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      chk_q     <= chk_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      idle_q    <= idle_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
      err_tmo_q <= err_tmo_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign pkt_valid    = w_draining;
  assign pkt_data     = w_draining ? w_buf_rdata : 8'h00;
  assign pkt_last     = w_draining && w_rd_at_last;
  assign pkt_len      = w_draining ? len_q : 8'h00;
  assign busy         = (state_q != ST_HUNT);
  assign err_length   = err_len_q;
  assign err_checksum = err_chk_q;
  assign err_timeout  = err_tmo_q;
  assign err_overflow = err_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_packet_ctrl.sv
// ============================================================================
// tb_serial_packet_ctrl: table-driven vectors plus timeout and max-length runs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_packet_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 16;

  localparam logic [3:0] E_NONE = 4'b0000;
  localparam logic [3:0] E_LEN  = 4'b1000;
  localparam logic [3:0] E_CHK  = 4'b0100;
  localparam logic [3:0] E_TMO  = 4'b0010;
  localparam logic [3:0] E_OVF  = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       pkt_ready = 1'b0;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_last;
  logic [7:0] pkt_len;
  logic       busy;
  logic       err_length;
  logic       err_checksum;
  logic       err_timeout;
  logic       err_overflow;

  always #5 clk = ~clk;

  serial_packet_ctrl #(
    .MAX_LEN   (MAX_LEN),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .byte_valid   (byte_valid),
    .byte_in      (byte_in),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_data     (pkt_data),
    .pkt_last     (pkt_last),
    .pkt_len      (pkt_len),
    .busy         (busy),
    .err_length   (err_length),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow)
  );

  typedef struct {
    logic       rst;
    logic       bv;
    logic [7:0] b;
    logic       rdy;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [7:0] len;
    logic       busy;
    logic [3:0] err;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_fail    = 0;

  task automatic add(input logic rst, input logic bv, input logic [7:0] b,
                     input logic rdy, input logic valid, input logic [7:0] data,
                     input logic last, input logic [7:0] len, input logic bsy,
                     input logic [3:0] err);
    vec_t v;
    v.rst = rst; v.bv = bv; v.b = b; v.rdy = rdy; v.valid = valid;
    v.data = data; v.last = last; v.len = len; v.busy = bsy; v.err = err;
    vecs.push_back(v);
  endtask

  // Framing byte that is expected to leave the block busy and silent.
  task automatic add_fb(input logic [7:0] b, input logic rdy);
    add(1'b0, 1'b1, b, rdy, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, E_NONE);
  endtask

  task automatic add_idle_zero();
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, E_NONE);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick(input logic rst, input logic bv, input logic [7:0] b,
                      input logic rdy);
    reset      = rst;
    byte_valid = bv;
    byte_in    = b;
    pkt_ready  = rdy;
    @(posedge clk);
    #1;
    n_applied++;
  endtask

  function automatic logic [3:0] errs();
    return {err_length, err_checksum, err_timeout, err_overflow};
  endfunction

  initial begin
    // Reset and idle
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, E_NONE);
    add_idle_zero();
    // Good packet A5 03 11 22 33 03, consumer always ready
    add_fb(8'hA5, 1'b1); add_fb(8'h03, 1'b1);
    add_fb(8'h11, 1'b1); add_fb(8'h22, 1'b1); add_fb(8'h33, 1'b1);
    add(1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 8'h11, 1'b0, 8'd3, 1'b1, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 8'd3, 1'b1, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 8'd3, 1'b1, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, E_NONE);
    // Same packet under toggling backpressure
    add_fb(8'hA5, 1'b0); add_fb(8'h03, 1'b0);
    add_fb(8'h11, 1'b0); add_fb(8'h22, 1'b0); add_fb(8'h33, 1'b0);
    add(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h11, 1'b0, 8'd3, 1'b1, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 8'd3, 1'b1, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 8'd3, 1'b1, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 8'd3, 1'b1, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 8'd3, 1'b1, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 8'd3, 1'b1, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, E_NONE);
    // Bad lengths 00 and 11 (> MAX_LEN), then a one-byte packet A5 01 7E 7F
    add_fb(8'hA5, 1'b0);
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, E_LEN);
    add_idle_zero();
    add_fb(8'hA5, 1'b0);
    add(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, E_LEN);
    add_idle_zero();
    add_fb(8'hA5, 1'b0); add_fb(8'h01, 1'b0); add_fb(8'h7E, 1'b0);
    add(1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h7E, 1'b1, 8'd1, 1'b1, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, E_NONE);
    // Checksum error: A5 02 AA 55 FE (FD would be correct)
    add_fb(8'hA5, 1'b1); add_fb(8'h02, 1'b1);
    add_fb(8'hAA, 1'b1); add_fb(8'h55, 1'b1);
    add(1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, E_CHK);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, E_NONE);
    // Overflow during a stalled drain, then reset mid-drain
    add_fb(8'hA5, 1'b0); add_fb(8'h01, 1'b0); add_fb(8'h42, 1'b0);
    add(1'b0, 1'b1, 8'h43, 1'b0, 1'b1, 8'h42, 1'b1, 8'd1, 1'b1, E_NONE);
    add(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 8'h42, 1'b1, 8'd1, 1'b1, E_OVF);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 1'b1, 8'd1, 1'b1, E_NONE);
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, E_NONE);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, E_NONE);
    add_fb(8'hA5, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, E_NONE);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst, vecs[i].bv, vecs[i].b, vecs[i].rdy);
      check("pkt_valid", i, 8'(pkt_valid), 8'(vecs[i].valid));
      check("pkt_data",  i, pkt_data,       vecs[i].data);
      check("pkt_last",  i, 8'(pkt_last),  8'(vecs[i].last));
      check("pkt_len",   i, pkt_len,        vecs[i].len);
      check("busy",      i, 8'(busy),      8'(vecs[i].busy));
      check("err",       i, 8'(errs()),    8'(vecs[i].err));
    end

    // Timeout: A5 02 AA then silence; abort after exactly TIMEOUT-1 idle cycles
    tick(1'b0, 1'b1, 8'hA5, 1'b1);
    tick(1'b0, 1'b1, 8'h02, 1'b1);
    tick(1'b0, 1'b1, 8'hAA, 1'b1);
    for (int k = 1; k < TIMEOUT - 1; k++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      check("tmo_early_err",  k, 8'(errs()), 8'(E_NONE));
      check("tmo_early_busy", k, 8'(busy),   8'd1);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    check("tmo_err",  0, 8'(errs()), 8'(E_TMO));
    check("tmo_busy", 0, 8'(busy),   8'd0);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    check("tmo_pulse_width", 0, 8'(errs()), 8'(E_NONE));

    // Byte arriving on the would-be timeout cycle is taken as payload
    tick(1'b0, 1'b1, 8'hA5, 1'b1);
    tick(1'b0, 1'b1, 8'h02, 1'b1);
    tick(1'b0, 1'b1, 8'hAA, 1'b1);
    for (int k = 1; k < TIMEOUT - 1; k++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1);
    end
    tick(1'b0, 1'b1, 8'h55, 1'b1);
    check("edge_err",  0, 8'(errs()), 8'(E_NONE));
    check("edge_busy", 0, 8'(busy),   8'd1);
    tick(1'b0, 1'b1, 8'hFD, 1'b1);
    check("edge_valid", 0, 8'(pkt_valid), 8'd1);
    check("edge_data0", 0, pkt_data,       8'hAA);
    check("edge_len",   0, pkt_len,        8'd2);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    check("edge_data1", 0, pkt_data,      8'h55);
    check("edge_last",  0, 8'(pkt_last), 8'd1);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    check("edge_done", 0, 8'(busy), 8'd0);

    // Maximum length: 16 bytes 00..0F, XOR of payload is 0 so CHK = 10
    tick(1'b0, 1'b1, 8'hA5, 1'b1);
    tick(1'b0, 1'b1, 8'h10, 1'b1);
    check("max_len_err", 0, 8'(errs()), 8'(E_NONE));
    for (int i = 0; i < MAX_LEN; i++) begin
      tick(1'b0, 1'b1, 8'(i), 1'b1);
    end
    tick(1'b0, 1'b1, 8'h10, 1'b1);
    check("max_valid", 0, 8'(pkt_valid), 8'd1);
    check("max_plen",  0, pkt_len,        8'd16);
    for (int i = 0; i < MAX_LEN; i++) begin
      check("max_data", i, pkt_data,      8'(i));
      check("max_last", i, 8'(pkt_last), 8'(i == MAX_LEN - 1));
      tick(1'b0, 1'b0, 8'h00, 1'b1);
    end
    check("max_done", 0, 8'(pkt_valid), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_packet_ctrl.md
Name: serial_packet_ctrl

Overview:
Framing controller that sits downstream of the serial byte receiver. It consumes the receiver's one-cycle byte strobe and byte value, and hunts for a sync byte. It then collects a length-prefixed payload into an internal buffer, verifies an XOR checksum, and presents the accepted packet byte-by-byte to a consumer over a valid/ready handshake. Length, checksum, timeout and overflow errors are reported as one-cycle pulses.

Parameters:
MAX_LEN, 16, maximum payload bytes per packet (1..255); sets buffer depth.
SYNC_BYTE, 8'hA5, packet start marker.
TIMEOUT, 4096, max idle cycles between bytes inside a packet before abort (>=2).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
byte_valid  in  1  one-cycle strobe: byte_in is a newly received byte
byte_in  in  8  received byte, valid only with byte_valid
pkt_valid  out  1  pkt_data holds a payload byte for the consumer
pkt_ready  in  1  consumer accepts pkt_data this cycle
pkt_data  out  8  current payload byte
pkt_last  out  1  pkt_data is the final payload byte
pkt_len  out  8  payload length of the packet being drained
busy  out  1  high in any state other than HUNT
err_length  out  1  pulse: LEN byte is 0 or greater than MAX_LEN
err_checksum  out  1  pulse: checksum mismatch
err_timeout  out  1  pulse: inter-byte gap exceeded inside a packet
err_overflow  out  1  pulse: byte arrived during DRAIN and was dropped

Behaviour:
- Clock is clk. Reset is synchronous and active-high, named reset. Reset is fully synchronous; there is no asynchronous path.
- Reset: state=HUNT. pkt_valid, pkt_last, busy and all err_* are 0. pkt_data=0, pkt_len=0, all counters 0. Buffer contents are don't-care.
- Reset asserted mid-packet or mid-drain aborts immediately. No error pulse is raised, and pkt_valid is 0 the next cycle.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK, where CHK = LEN ^ payload[0] ^ ... ^ payload[LEN-1].
- Every state transition occurs only on a cycle with byte_valid=1, except the timeout and drain exits.
- States:
  - HUNT: byte_in==SYNC_BYTE -> LEN. Any other byte is ignored silently.
  - LEN: byte in 1..MAX_LEN -> latch len, set chk=byte, wr_ptr=0 -> PAYLOAD. Otherwise pulse err_length -> HUNT. A SYNC_BYTE value here is treated as a length.
  - PAYLOAD: write byte to buf[wr_ptr], chk^=byte, wr_ptr++. When wr_ptr==len-1 on a write -> CHECK.
  - CHECK: byte==chk -> rd_ptr=0 -> DRAIN. Otherwise pulse err_checksum -> HUNT.
  - DRAIN: pkt_valid=1, pkt_data=buf[rd_ptr], pkt_last=(rd_ptr==len-1), pkt_len=len. Each cycle with pkt_valid&&pkt_ready advances rd_ptr. The transfer with pkt_last -> HUNT, so pkt_valid=0 the next cycle.
- Latency: pkt_valid rises exactly 1 cycle after the byte_valid cycle carrying a correct CHK.
- Handshake: while pkt_valid&&!pkt_ready, pkt_data, pkt_last and pkt_len stay stable. pkt_valid never drops before its transfer completes. pkt_ready is ignored outside DRAIN.
- Overflow: byte_valid in DRAIN drops the byte, pulses err_overflow, and leaves the state unchanged. A byte arriving on the final-transfer cycle is also dropped. HUNT resumes on the next byte.
- Timeout:
  - The idle counter clears on every byte_valid and on every entry to LEN.
  - It increments each cycle without byte_valid while in LEN, PAYLOAD or CHECK.
  - When the counter reaches TIMEOUT-1 with no byte that cycle: pulse err_timeout -> HUNT.
  - byte_valid in the same cycle that would time out wins: the byte is processed and the counter cleared.
  - The counter is idle in HUNT and DRAIN.
- All err_* pulses are registered, one cycle wide, at most one per byte, and mutually exclusive.
- Widths:
  - wr_ptr and rd_ptr are $clog2(MAX_LEN) bits, with a minimum of 1.
  - The idle counter is $clog2(TIMEOUT) bits.
  - len is 8 bits; chk is 8 bits and is XOR-only with no carries.

Decomposition:
- Shared package serial_pkg holds:
  - the state enumeration (HUNT, LEN, PAYLOAD, CHECK, DRAIN);
  - the default SYNC_BYTE constant;
  - a localparam function for pointer width (clog2 with a minimum of 1).
- Sub-module pkt_buffer: MAX_LEN x 8 register file with one synchronous write port and one combinational read port, no reset on the storage.
- The FSM, checksum, pointers and timeout counter stay in serial_packet_ctrl.

Test Plan:
- Good packet: A5,03,11,22,33,CHK=03^11^22^33=03, pkt_ready=1 -> pkt_valid rises 1 cycle after the CHK strobe. Output is 11,22,33 on consecutive cycles, pkt_last only with 33, pkt_len=3, no err pulses.
- Backpressure: same packet with pkt_ready toggling 0/1 each cycle -> each byte held stable while ready=0, 3 transfers total, then busy=0.
- Bad length: A5,00 -> err_length pulse, HUNT. Then A5,11 with MAX_LEN=16 -> err_length again. A following valid packet is received correctly.
- Checksum error: A5,02,AA,55,FE (correct CHK is FD) -> err_checksum single pulse, pkt_valid never asserts.
- Timeout/boundary: A5,02,AA then TIMEOUT cycles of silence -> err_timeout after exactly TIMEOUT-1 idle cycles. Repeat with a byte arriving on that exact cycle -> no timeout, and that byte is accepted as payload.
- Overflow + reset: feed a byte during DRAIN with pkt_ready=0 -> err_overflow, drain unaffected. Then assert reset mid-DRAIN -> pkt_valid=0 next cycle, state HUNT, no error pulse.
